// File: rtl/alu_exec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_exec
// Purpose  : RV32IM execution unit. Single-cycle ALU/branch ops, a 2-stage
//            multiplier and a radix-2 restoring divider on one CDB lane.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec #(
    parameter int XLEN     = 32,
    parameter int ROB_BIT  = 4,
    parameter int OPT_W    = 6,
    parameter int DIV_ITER = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               alu_rb,
    input  logic               alu_ena,
    input  logic [OPT_W-1:0]   alu_opt,
    input  logic [XLEN-1:0]    alu_val1,
    input  logic [XLEN-1:0]    alu_val2,
    input  logic [XLEN-1:0]    alu_imm,
    input  logic [ROB_BIT-1:0] alu_rob_idx,
    output logic               alu_busy,
    output logic               cdb_alu_valid,
    output logic [ROB_BIT-1:0] cdb_alu_src,
    output logic [XLEN-1:0]    cdb_alu_val,
    output logic               cdb_alu_taken
);

    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(DIV_ITER);

    localparam logic [OPT_W-1:0] c_OPT_BEQ  = OPT_W'(5),  c_OPT_BNE   = OPT_W'(6),
                                 c_OPT_BLT  = OPT_W'(7),  c_OPT_BGE   = OPT_W'(8),
                                 c_OPT_BLTU = OPT_W'(9),  c_OPT_BGEU  = OPT_W'(10),
                                 c_OPT_ADDI = OPT_W'(19), c_OPT_SLTI  = OPT_W'(20),
                                 c_OPT_SLTIU = OPT_W'(21), c_OPT_XORI = OPT_W'(22),
                                 c_OPT_ORI  = OPT_W'(23), c_OPT_ANDI  = OPT_W'(24),
                                 c_OPT_SLLI = OPT_W'(25), c_OPT_SRLI  = OPT_W'(26),
                                 c_OPT_SRAI = OPT_W'(27), c_OPT_ADD   = OPT_W'(28),
                                 c_OPT_SUB  = OPT_W'(29), c_OPT_SLL   = OPT_W'(30),
                                 c_OPT_SLT  = OPT_W'(31), c_OPT_SLTU  = OPT_W'(32),
                                 c_OPT_XOR  = OPT_W'(33), c_OPT_SRL   = OPT_W'(34),
                                 c_OPT_SRA  = OPT_W'(35), c_OPT_OR    = OPT_W'(36),
                                 c_OPT_AND  = OPT_W'(37), c_OPT_MUL   = OPT_W'(38),
                                 c_OPT_MULH = OPT_W'(39), c_OPT_MULHSU = OPT_W'(40),
                                 c_OPT_MULHU = OPT_W'(41), c_OPT_DIV  = OPT_W'(42),
                                 c_OPT_DIVU = OPT_W'(43), c_OPT_REM   = OPT_W'(44),
                                 c_OPT_REMU = OPT_W'(45);

    localparam logic [XLEN-1:0] c_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DIV_RUN  = 2'd1,
        S_DIV_DONE = 2'd2
    } state_t;

    state_t               r_state_q, w_state_d;
    logic                 r_cdb_valid_q, w_cdb_valid_d;
    logic [ROB_BIT-1:0]   r_cdb_src_q, w_cdb_src_d;
    logic [XLEN-1:0]      r_cdb_val_q, w_cdb_val_d;
    logic                 r_cdb_taken_q, w_cdb_taken_d;
    logic                 r_mul_vld_q, w_mul_vld_d;
    logic                 r_mul_hi_q, w_mul_hi_d;
    logic [ROB_BIT-1:0]   r_mul_tag_q, w_mul_tag_d;
    logic [2*XLEN-1:0]    r_mul_prod_q, w_mul_prod_d;
    logic [XLEN-1:0]      r_div_rem_q, w_div_rem_d;
    logic [XLEN-1:0]      r_div_quo_q, w_div_quo_d;
    logic [XLEN-1:0]      r_div_dvs_q, w_div_dvs_d;
    logic [XLEN-1:0]      r_div_dvd_q, w_div_dvd_d;
    logic [CNT_W-1:0]     r_div_cnt_q, w_div_cnt_d;
    logic [ROB_BIT-1:0]   r_div_tag_q, w_div_tag_d;
    logic                 r_div_negq_q, w_div_negq_d;
    logic                 r_div_negr_q, w_div_negr_d;
    logic                 r_div_isrem_q, w_div_isrem_d;
    logic                 r_div_zero_q, w_div_zero_d;
    logic                 r_div_ovf_q, w_div_ovf_d;

    logic                 w_is_itype, w_is_mul, w_is_div, w_div_sgn;
    logic                 w_busy_st, w_accept, w_alu_taken;
    logic [XLEN-1:0]      w_op2, w_alu_res;
    logic [SH_W-1:0]      w_shamt;
    logic [2*XLEN-1:0]    w_mul_a, w_mul_b;
    logic                 w_dvd_neg, w_dvs_neg, w_div_ge;
    logic [XLEN:0]        w_rem_sh, w_rem_sub;
    logic [XLEN-1:0]      w_rem_nxt, w_quo_nxt, w_quo_fin, w_rem_fin, w_div_res;

    always_comb begin
        w_is_itype = alu_opt inside {c_OPT_ADDI, c_OPT_SLTI, c_OPT_SLTIU, c_OPT_XORI,
                                     c_OPT_ORI, c_OPT_ANDI, c_OPT_SLLI, c_OPT_SRLI, c_OPT_SRAI};
        w_is_mul   = alu_opt inside {c_OPT_MUL, c_OPT_MULH, c_OPT_MULHSU, c_OPT_MULHU};
        w_is_div   = alu_opt inside {c_OPT_DIV, c_OPT_DIVU, c_OPT_REM, c_OPT_REMU};
        w_op2      = w_is_itype ? alu_imm : alu_val2;
        w_shamt    = w_op2[SH_W-1:0];
        w_alu_res   = alu_imm;
        w_alu_taken = 1'b0;
        case (alu_opt)
            c_OPT_ADD,  c_OPT_ADDI:  w_alu_res = alu_val1 + w_op2;
            c_OPT_SUB:               w_alu_res = alu_val1 - w_op2;
            c_OPT_SLL,  c_OPT_SLLI:  w_alu_res = alu_val1 << w_shamt;
            c_OPT_SLT,  c_OPT_SLTI:  w_alu_res = {{(XLEN-1){1'b0}}, $signed(alu_val1) < $signed(w_op2)};
            c_OPT_SLTU, c_OPT_SLTIU: w_alu_res = {{(XLEN-1){1'b0}}, alu_val1 < w_op2};
            c_OPT_XOR,  c_OPT_XORI:  w_alu_res = alu_val1 ^ w_op2;
            c_OPT_OR,   c_OPT_ORI:   w_alu_res = alu_val1 | w_op2;
            c_OPT_AND,  c_OPT_ANDI:  w_alu_res = alu_val1 & w_op2;
            c_OPT_SRL,  c_OPT_SRLI:  w_alu_res = alu_val1 >> w_shamt;
            c_OPT_SRA,  c_OPT_SRAI:  w_alu_res = $signed(alu_val1) >>> w_shamt;
            c_OPT_BEQ:  w_alu_taken = (alu_val1 == alu_val2);
            c_OPT_BNE:  w_alu_taken = (alu_val1 != alu_val2);
            c_OPT_BLT:  w_alu_taken = ($signed(alu_val1) <  $signed(alu_val2));
            c_OPT_BGE:  w_alu_taken = ($signed(alu_val1) >= $signed(alu_val2));
            c_OPT_BLTU: w_alu_taken = (alu_val1 <  alu_val2);
            c_OPT_BGEU: w_alu_taken = (alu_val1 >= alu_val2);
            default:    w_alu_res   = alu_imm;
        endcase

        // Sign-extend to 2*XLEN so the unsigned product's low 2*XLEN bits are exact
        w_mul_a = {{XLEN{(alu_opt == c_OPT_MULH || alu_opt == c_OPT_MULHSU) && alu_val1[XLEN-1]}}, alu_val1};
        w_mul_b = {{XLEN{(alu_opt == c_OPT_MULH) && alu_val2[XLEN-1]}}, alu_val2};

        w_div_sgn = alu_opt inside {c_OPT_DIV, c_OPT_REM};
        w_dvd_neg = w_div_sgn && alu_val1[XLEN-1];
        w_dvs_neg = w_div_sgn && alu_val2[XLEN-1];

        w_rem_sh  = {r_div_rem_q, r_div_quo_q[XLEN-1]};
        w_rem_sub = w_rem_sh - {1'b0, r_div_dvs_q};
        w_div_ge  = !w_rem_sub[XLEN];
        w_rem_nxt = w_div_ge ? w_rem_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];
        w_quo_nxt = {r_div_quo_q[XLEN-2:0], w_div_ge};
        if (r_div_zero_q) begin
            w_quo_fin = '1;
            w_rem_fin = r_div_dvd_q;
        end else if (r_div_ovf_q) begin
            w_quo_fin = c_INT_MIN;
            w_rem_fin = '0;
        end else begin
            w_quo_fin = r_div_negq_q ? -w_quo_nxt : w_quo_nxt;
            w_rem_fin = r_div_negr_q ? -w_rem_nxt : w_rem_nxt;
        end
        w_div_res = r_div_isrem_q ? w_rem_fin : w_quo_fin;
    end

    assign w_busy_st = r_mul_vld_q || (r_state_q == S_DIV_RUN);
    assign alu_busy  = w_busy_st || (alu_ena && (w_is_mul || w_is_div));
    assign w_accept  = alu_ena && !w_busy_st;

    always_comb begin
        w_state_d     = r_state_q;
        w_cdb_valid_d = r_cdb_valid_q;
        w_cdb_src_d   = r_cdb_src_q;
        w_cdb_val_d   = r_cdb_val_q;
        w_cdb_taken_d = r_cdb_taken_q;
        w_mul_vld_d   = r_mul_vld_q;
        w_mul_hi_d    = r_mul_hi_q;
        w_mul_tag_d   = r_mul_tag_q;
        w_mul_prod_d  = r_mul_prod_q;
        w_div_rem_d   = r_div_rem_q;
        w_div_quo_d   = r_div_quo_q;
        w_div_dvs_d   = r_div_dvs_q;
        w_div_dvd_d   = r_div_dvd_q;
        w_div_cnt_d   = r_div_cnt_q;
        w_div_tag_d   = r_div_tag_q;
        w_div_negq_d  = r_div_negq_q;
        w_div_negr_d  = r_div_negr_q;
        w_div_isrem_d = r_div_isrem_q;
        w_div_zero_d  = r_div_zero_q;
        w_div_ovf_d   = r_div_ovf_q;
        if (alu_rb) begin
            w_cdb_valid_d = 1'b0;
            w_mul_vld_d   = 1'b0;
            w_state_d     = S_IDLE;
        end else if (rdy) begin
            w_cdb_valid_d = 1'b0;
            w_mul_vld_d   = 1'b0;
            if (r_state_q == S_DIV_DONE) w_state_d = S_IDLE;
            if (r_mul_vld_q) begin
                w_cdb_valid_d = 1'b1;
                w_cdb_src_d   = r_mul_tag_q;
                w_cdb_val_d   = r_mul_hi_q ? r_mul_prod_q[2*XLEN-1:XLEN] : r_mul_prod_q[XLEN-1:0];
                w_cdb_taken_d = 1'b0;
            end
            if (r_state_q == S_DIV_RUN) begin
                w_div_rem_d = w_rem_nxt;
                w_div_quo_d = w_quo_nxt;
                w_div_cnt_d = r_div_cnt_q + CNT_W'(1);
                // Fix-up folds into the last step so the result lands on the CDB one cycle later
                if (r_div_cnt_q == CNT_W'(DIV_ITER-1)) begin
                    w_state_d     = S_DIV_DONE;
                    w_cdb_valid_d = 1'b1;
                    w_cdb_src_d   = r_div_tag_q;
                    w_cdb_val_d   = w_div_res;
                    w_cdb_taken_d = 1'b0;
                end
            end
            if (w_accept) begin
                if (w_is_mul) begin
                    w_mul_vld_d  = 1'b1;
                    w_mul_hi_d   = (alu_opt != c_OPT_MUL);
                    w_mul_tag_d  = alu_rob_idx;
                    w_mul_prod_d = w_mul_a * w_mul_b;
                end else if (w_is_div) begin
                    w_state_d     = S_DIV_RUN;
                    w_div_cnt_d   = '0;
                    w_div_rem_d   = '0;
                    w_div_quo_d   = w_dvd_neg ? -alu_val1 : alu_val1;
                    w_div_dvs_d   = w_dvs_neg ? -alu_val2 : alu_val2;
                    w_div_dvd_d   = alu_val1;
                    w_div_tag_d   = alu_rob_idx;
                    w_div_negq_d  = w_dvd_neg ^ w_dvs_neg;
                    w_div_negr_d  = w_dvd_neg;
                    w_div_isrem_d = (alu_opt == c_OPT_REM) || (alu_opt == c_OPT_REMU);
                    w_div_zero_d  = (alu_val2 == '0);
                    w_div_ovf_d   = w_div_sgn && (alu_val1 == c_INT_MIN) && (alu_val2 == '1);
                end else begin
                    w_cdb_valid_d = 1'b1;
                    w_cdb_src_d   = alu_rob_idx;
                    w_cdb_val_d   = w_alu_res;
                    w_cdb_taken_d = w_alu_taken;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_cdb_valid_q <= 1'b0;
            r_cdb_src_q   <= '0;
            r_cdb_val_q   <= '0;
            r_cdb_taken_q <= 1'b0;
            r_mul_vld_q   <= 1'b0;
            r_mul_hi_q    <= 1'b0;
            r_mul_tag_q   <= '0;
            r_mul_prod_q  <= '0;
            r_div_rem_q   <= '0;
            r_div_quo_q   <= '0;
            r_div_dvs_q   <= '0;
            r_div_dvd_q   <= '0;
            r_div_cnt_q   <= '0;
            r_div_tag_q   <= '0;
            r_div_negq_q  <= 1'b0;
            r_div_negr_q  <= 1'b0;
            r_div_isrem_q <= 1'b0;
            r_div_zero_q  <= 1'b0;
            r_div_ovf_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cdb_valid_q <= w_cdb_valid_d;
            r_cdb_src_q   <= w_cdb_src_d;
            r_cdb_val_q   <= w_cdb_val_d;
            r_cdb_taken_q <= w_cdb_taken_d;
            r_mul_vld_q   <= w_mul_vld_d;
            r_mul_hi_q    <= w_mul_hi_d;
            r_mul_tag_q   <= w_mul_tag_d;
            r_mul_prod_q  <= w_mul_prod_d;
            r_div_rem_q   <= w_div_rem_d;
            r_div_quo_q   <= w_div_quo_d;
            r_div_dvs_q   <= w_div_dvs_d;
            r_div_dvd_q   <= w_div_dvd_d;
            r_div_cnt_q   <= w_div_cnt_d;
            r_div_tag_q   <= w_div_tag_d;
            r_div_negq_q  <= w_div_negq_d;
            r_div_negr_q  <= w_div_negr_d;
            r_div_isrem_q <= w_div_isrem_d;
            r_div_zero_q  <= w_div_zero_d;
            r_div_ovf_q   <= w_div_ovf_d;
        end
    end

    assign cdb_alu_valid = r_cdb_valid_q;
    assign cdb_alu_src   = r_cdb_src_q;
    assign cdb_alu_val   = r_cdb_val_q;
    assign cdb_alu_taken = r_cdb_taken_q;

    // Issuing into an occupied unit is an RS bug; the op is silently dropped in hardware
    a_no_issue_when_busy: assert property (@(posedge clk) disable iff (rst)
        !(rdy && !alu_rb && alu_ena && w_busy_st));

endmodule
`default_nettype wire
